fwd_hazard_unit: RTL and testbench

- Parametrised operand-forwarding and load-use interlock unit for the superscalar pipeline.
- Sits at the ID/RF boundary. For every source operand of every issue way, it selects the youngest in-flight producer across all downstream stages and ways, or the register file.
- Stalls the front end on load-use hazards with a configurable penalty, and keeps saturating performance counters.

---
 rtl/fwd_hazard_unit.sv | 127 ++++++++++++
 tb/tb_fwd_hazard_unit.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fwd_hazard_unit.sv
// Operand-forwarding select and load-use interlock at the ID/RF boundary.
// For each source slot, the youngest matching in-flight producer wins. Load-use hazards stall the front end.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_RUN   | normal issue; a load-use hazard stalls in this cycle
// ST_STALL | extra penalty cycles; the down-counter holds the cycles left
module fwd_hazard_unit #(
    parameter int NUM_WAYS   = 2,
    parameter int NUM_STAGES = 3,
    parameter int REG_W      = 3,
    parameter int LOAD_STALL = 1,
    parameter int CNT_W      = 16,
    localparam int SEL_W     = $clog2(NUM_STAGES*NUM_WAYS+1)
) (
    input  logic                                clk,
    input  logic                                reset_n,
    input  logic [NUM_WAYS*2*REG_W-1:0]         src_addr_i,
    input  logic [NUM_WAYS*2-1:0]               src_vld_i,
    input  logic [NUM_STAGES*NUM_WAYS*REG_W-1:0] dst_addr_i,
    input  logic [NUM_STAGES*NUM_WAYS-1:0]      dst_wb_i,
    input  logic [NUM_STAGES*NUM_WAYS-1:0]      dst_vld_i,
    input  logic [NUM_WAYS-1:0]                 ex_is_load_i,
    input  logic                                flush_i,
    output logic [NUM_WAYS*2*SEL_W-1:0]         fwd_sel_o,
    output logic                                stall_o,
    output logic [CNT_W-1:0]                    stall_cnt_o,
    output logic [CNT_W-1:0]                    fwd_cnt_o
);

    localparam int NUM_SLOTS = NUM_WAYS*2;
    localparam int CTR_W     = $clog2(LOAD_STALL+1);

    typedef enum logic {ST_RUN, ST_STALL} state_t;

    state_t             state_q, state_d;
    logic [CTR_W-1:0]   cnt_q, cnt_d;
    logic [SEL_W-1:0]   slot_sel [NUM_SLOTS];
    logic               hazard;
    logic               any_fwd;

    // Scan from lowest priority to highest so the last match is the winner.
    always_comb begin
        fwd_sel_o = '0;
        for (int s = 0; s < NUM_SLOTS; s++) begin
            slot_sel[s] = '0;
            for (int st = NUM_STAGES-1; st >= 0; st--) begin
                for (int w = 0; w < NUM_WAYS; w++) begin
                    if (src_vld_i[s] && dst_vld_i[st*NUM_WAYS+w] && dst_wb_i[st*NUM_WAYS+w] &&
                        src_addr_i[s*REG_W +: REG_W] == dst_addr_i[(st*NUM_WAYS+w)*REG_W +: REG_W]) begin
                        slot_sel[s] = SEL_W'(st*NUM_WAYS + w + 1);
                    end
                end
            end
            if (!reset_n) begin
                slot_sel[s] = '0;
            end
            fwd_sel_o[s*SEL_W +: SEL_W] = slot_sel[s];
        end
    end

    // A hazard exists only when the winning producer is a stage-0 load.
    always_comb begin
        hazard  = 1'b0;
        any_fwd = 1'b0;
        for (int s = 0; s < NUM_SLOTS; s++) begin
            if (slot_sel[s] != '0) begin
                any_fwd = 1'b1;
            end
            for (int w = 0; w < NUM_WAYS; w++) begin
                if (slot_sel[s] == SEL_W'(w + 1) && ex_is_load_i[w]) begin
                    hazard = 1'b1;
                end
            end
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        stall_o = 1'b0;
        case (state_q)
            ST_RUN: begin
                stall_o = hazard;
                if (hazard && LOAD_STALL > 1) begin
                    state_d = ST_STALL;
                    cnt_d   = CTR_W'(LOAD_STALL - 1);
                end
            end
            ST_STALL: begin
                stall_o = 1'b1;
                cnt_d   = cnt_q - 1'b1;
                if (cnt_q == CTR_W'(1)) begin
                    state_d = ST_RUN;
                end
            end
            default: begin
                state_d = ST_RUN;
                cnt_d   = '0;
            end
        endcase
        if (flush_i) begin
            stall_o = 1'b0;
            state_d = ST_RUN;
            cnt_d   = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= ST_RUN;
            cnt_q       <= '0;
            stall_cnt_o <= '0;
            fwd_cnt_o   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (stall_o && stall_cnt_o != '1) begin
                stall_cnt_o <= stall_cnt_o + 1'b1;
            end
            if (any_fwd && !stall_o && fwd_cnt_o != '1) begin
                fwd_cnt_o <= fwd_cnt_o + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Scoreboard bench for fwd_hazard_unit: two instances (LOAD_STALL 1 / CNT_W 4 and LOAD_STALL 3 / CNT_W 16)
// share stimulus; a priority-scan and stall-budget model predicts every output.
module tb_fwd_hazard_unit;

    localparam int NW  = 2;
    localparam int NS  = 3;
    localparam int RW  = 3;
    localparam int SW  = 3;
    localparam int NSL = NW*2;
    localparam int NE  = NS*NW;

    logic                clk = 1'b0;
    logic                reset_n;
    logic [NSL*RW-1:0]   src_addr;
    logic [NSL-1:0]      src_vld;
    logic [NE*RW-1:0]    dst_addr;
    logic [NE-1:0]       dst_wb;
    logic [NE-1:0]       dst_vld;
    logic [NW-1:0]       ex_is_load;
    logic                flush;
    logic [NSL*SW-1:0]   sel1, sel3;
    logic                stall1, stall3;
    logic [3:0]          scnt1, fcnt1;
    logic [15:0]         scnt3, fcnt3;

    fwd_hazard_unit #(.NUM_WAYS(NW), .NUM_STAGES(NS), .REG_W(RW), .LOAD_STALL(1), .CNT_W(4)) dut1 (
        .clk(clk), .reset_n(reset_n), .src_addr_i(src_addr), .src_vld_i(src_vld),
        .dst_addr_i(dst_addr), .dst_wb_i(dst_wb), .dst_vld_i(dst_vld), .ex_is_load_i(ex_is_load),
        .flush_i(flush), .fwd_sel_o(sel1), .stall_o(stall1), .stall_cnt_o(scnt1), .fwd_cnt_o(fcnt1)
    );

    fwd_hazard_unit #(.NUM_WAYS(NW), .NUM_STAGES(NS), .REG_W(RW), .LOAD_STALL(3), .CNT_W(16)) dut3 (
        .clk(clk), .reset_n(reset_n), .src_addr_i(src_addr), .src_vld_i(src_vld),
        .dst_addr_i(dst_addr), .dst_wb_i(dst_wb), .dst_vld_i(dst_vld), .ex_is_load_i(ex_is_load),
        .flush_i(flush), .fwd_sel_o(sel3), .stall_o(stall3), .stall_cnt_o(scnt3), .fwd_cnt_o(fcnt3)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [NSL*SW-1:0] sel;
        bit st0, st1;
        int sc0, fc0, sc1, fc1;
    } exp_t;

    exp_t q[$];
    int   n_cmp = 0;
    int   n_err = 0;
    int   rem[2];
    int   scm[2];
    int   fcm[2];
    int   ls[2]   = '{1, 3};
    int   cmax[2] = '{15, 65535};

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic int ref_sel(input int s);
        if (!src_vld[s]) return 0;
        for (int st = 0; st < NS; st++) begin
            for (int w = NW-1; w >= 0; w--) begin
                int e = st*NW + w;
                if (dst_vld[e] && dst_wb[e] && src_addr[s*RW +: RW] == dst_addr[e*RW +: RW]) return e + 1;
            end
        end
        return 0;
    endfunction

    function automatic bit model_hazard();
        for (int s = 0; s < NSL; s++) begin
            int r = ref_sel(s);
            if (r >= 1 && r <= NW && ex_is_load[r-1]) return 1'b1;
        end
        return 1'b0;
    endfunction

    function automatic bit model_any_fwd();
        for (int s = 0; s < NSL; s++) if (ref_sel(s) != 0) return 1'b1;
        return 1'b0;
    endfunction

    function automatic bit model_stall(input int d);
        if (flush) return 1'b0;
        if (rem[d] > 0) return 1'b1;
        return model_hazard();
    endfunction

    function automatic int get_sel(input logic [NSL*SW-1:0] v, input int s);
        return int'(v[s*SW +: SW]);
    endfunction

    task automatic clr();
        src_addr = '0; src_vld = '0; dst_addr = '0; dst_wb = '0; dst_vld = '0;
        ex_is_load = '0; flush = 1'b0;
    endtask

    task automatic set_src(input int s, input int a);
        src_addr[s*RW +: RW] = RW'(a);
        src_vld[s] = 1'b1;
    endtask

    task automatic set_dst(input int e, input int a, input bit v);
        dst_addr[e*RW +: RW] = RW'(a);
        dst_wb[e]  = 1'b1;
        dst_vld[e] = v;
    endtask

    // Push the prediction for the current inputs, then compare at the falling edge.
    task automatic eval();
        exp_t x;
        x.sel = '0;
        for (int s = 0; s < NSL; s++) x.sel[s*SW +: SW] = SW'(ref_sel(s));
        x.st0 = model_stall(0); x.st1 = model_stall(1);
        x.sc0 = scm[0]; x.fc0 = fcm[0]; x.sc1 = scm[1]; x.fc1 = fcm[1];
        q.push_back(x);
        @(negedge clk);
        x = q.pop_front();
        for (int s = 0; s < NSL; s++) begin
            check($sformatf("sel1_slot%0d", s), get_sel(sel1, s), get_sel(x.sel, s));
            check($sformatf("sel3_slot%0d", s), get_sel(sel3, s), get_sel(x.sel, s));
        end
        check("stall1", int'(stall1), int'(x.st0));
        check("stall3", int'(stall3), int'(x.st1));
        check("stall_cnt1", int'(scnt1), x.sc0);
        check("fwd_cnt1", int'(fcnt1), x.fc0);
        check("stall_cnt3", int'(scnt3), x.sc1);
        check("fwd_cnt3", int'(fcnt3), x.fc1);
    endtask

    task automatic tick();
        bit h, af, st;
        @(posedge clk);
        h  = model_hazard();
        af = model_any_fwd();
        for (int d = 0; d < 2; d++) begin
            st = model_stall(d);
            if (st && scm[d] < cmax[d]) scm[d]++;
            if (af && !st && fcm[d] < cmax[d]) fcm[d]++;
            if (flush) rem[d] = 0;
            else if (rem[d] > 0) rem[d]--;
            else if (h) rem[d] = ls[d] - 1;
        end
        #1;
    endtask

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            rem[d] = 0; scm[d] = 0; fcm[d] = 0;
        end
    endtask

    task automatic load_use_setup();
        clr();
        set_dst(0, 2, 1'b1);
        ex_is_load[0] = 1'b1;
        set_src(2, 2);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        model_reset();
        reset_n = 1'b0;
        clr();
        set_src(0, 3);
        set_dst(0, 3, 1'b1);
        #1;
        check("rst_sel1_slot0", get_sel(sel1, 0), 0);
        check("rst_sel3_slot0", get_sel(sel3, 0), 0);
        check("rst_stall3", int'(stall3), 0);
        check("rst_scnt3", int'(scnt3), 0);
        check("rst_fcnt1", int'(fcnt1), 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset_n = 1'b1;

        // Same-stage priority: younger way wins, then falls back to way 0.
        clr();
        set_src(0, 3);
        set_dst(0, 3, 1'b1);
        set_dst(1, 3, 1'b1);
        eval();
        check("prio_young", get_sel(sel1, 0), 2);
        tick();
        dst_vld[1] = 1'b0;
        eval();
        check("prio_old", get_sel(sel1, 0), 1);
        tick();

        // Stage priority with a squashed producer.
        clr();
        set_src(3, 5);
        set_dst(3, 5, 1'b0);
        set_dst(4, 5, 1'b1);
        eval();
        check("squash_slot3", get_sel(sel3, 3), 5);
        tick();
        src_vld[3] = 1'b0;
        eval();
        check("novld_slot3", get_sel(sel3, 3), 0);
        tick();

        // Load-use: one stall cycle for dut1, three for dut3.
        load_use_setup();
        eval();
        check("lu_stall1_t0", int'(stall1), 1);
        check("lu_stall3_t0", int'(stall3), 1);
        tick();
        clr();
        set_dst(2, 2, 1'b1);
        set_src(2, 2);
        eval();
        check("lu_stall1_t1", int'(stall1), 0);
        check("lu_scnt1_t1", int'(scnt1), 1);
        check("lu_slot2_t1", get_sel(sel1, 2), 3);
        check("lu_stall3_t1", int'(stall3), 1);
        tick();
        eval();
        check("lu_stall3_t2", int'(stall3), 1);
        tick();
        eval();
        check("lu_stall3_t3", int'(stall3), 0);
        check("lu_scnt3_t3", int'(scnt3), 3);
        tick();

        // Flush in the middle of the long stall.
        load_use_setup();
        eval();
        tick();
        clr();
        flush = 1'b1;
        eval();
        check("flush_stall3", int'(stall3), 0);
        tick();
        flush = 1'b0;
        eval();
        check("flush_run3", int'(stall3), 0);
        tick();

        // Asynchronous reset in the middle of a stall.
        load_use_setup();
        eval();
        tick();
        clr();
        set_src(0, 1);
        set_dst(2, 1, 1'b1);
        eval();
        check("pre_rst_stall3", int'(stall3), 1);
        reset_n = 1'b0;
        #1;
        check("mid_rst_stall3", int'(stall3), 0);
        check("mid_rst_scnt3", int'(scnt3), 0);
        check("mid_rst_fcnt3", int'(fcnt3), 0);
        check("mid_rst_scnt1", int'(scnt1), 0);
        check("mid_rst_sel3", get_sel(sel3, 0), 0);
        model_reset();
        @(posedge clk);
        #1;
        reset_n = 1'b1;
        eval();
        check("post_rst_stall3", int'(stall3), 0);
        tick();

        // Continuous forwarding saturates the 4-bit counter.
        for (int i = 0; i < 20; i++) begin
            eval();
            tick();
        end
        eval();
        check("sat_fcnt1", int'(fcnt1), 15);
        tick();

        // Random traffic on a narrow register range to provoke many matches.
        for (int i = 0; i < 200; i++) begin
            for (int s = 0; s < NSL; s++) begin
                src_addr[s*RW +: RW] = RW'($urandom_range(0, 3));
                src_vld[s] = 1'($urandom_range(0, 1));
            end
            for (int e = 0; e < NE; e++) begin
                dst_addr[e*RW +: RW] = RW'($urandom_range(0, 3));
                dst_wb[e]  = 1'($urandom_range(0, 1));
                dst_vld[e] = 1'($urandom_range(0, 1));
            end
            ex_is_load = NW'($urandom_range(0, 3));
            flush = ($urandom_range(0, 9) == 0);
            eval();
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
